// File: rtl/inst_encoder_if.sv
// Request/result bus of the RV32I instruction encoder.
// Also carries the decoder's type codes (TYPE_BIT and LUI..AND) so that
// encoder and decoder agree on one numbering.
//   slave  : encoder side (takes requests, presents encoded words)
//   master : producer/consumer side
`ifndef INST_TYPE_CODES_DEFINED
`define INST_TYPE_CODES_DEFINED
`define TYPE_BIT 6
`define LUI   6'd0
`define AUIPC 6'd1
`define JAL   6'd2
`define JALR  6'd3
`define BEQ   6'd4
`define BNE   6'd5
`define BLT   6'd6
`define BGE   6'd7
`define BLTU  6'd8
`define BGEU  6'd9
`define LB    6'd10
`define LH    6'd11
`define LW    6'd12
`define LBU   6'd13
`define LHU   6'd14
`define SB    6'd15
`define SH    6'd16
`define SW    6'd17
`define ADDI  6'd18
`define SLTI  6'd19
`define SLTIU 6'd20
`define XORI  6'd21
`define ORI   6'd22
`define ANDI  6'd23
`define SLLI  6'd24
`define SRLI  6'd25
`define SRAI  6'd26
`define ADD   6'd27
`define SUB   6'd28
`define SLL   6'd29
`define SLT   6'd30
`define SLTU  6'd31
`define XOR   6'd32
`define SRL   6'd33
`define SRA   6'd34
`define OR    6'd35
`define AND   6'd36
`endif

interface inst_encoder_if;
  logic                 req_valid;
  logic                 req_ready;
  logic [`TYPE_BIT-1:0] type_in;
  logic [4:0]           rs1_in;
  logic [4:0]           rs2_in;
  logic [4:0]           rd_in;
  logic [31:0]          imm_in;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [31:0]          inst_out;
  logic                 err_out;

  modport master (
    output req_valid, type_in, rs1_in, rs2_in, rd_in, imm_in, inst_ready,
    input  req_ready, inst_valid, inst_out, err_out
  );

  modport slave (
    input  req_valid, type_in, rs1_in, rs2_in, rd_in, imm_in, inst_ready,
    output req_ready, inst_valid, inst_out, err_out
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder with an output FIFO.
// Turns a decoded instruction (type, rs1, rs2, rd, imm) into its 32-bit
// machine word and queues it behind valid/ready handshakes.
// Ports:
//   clk_in   : clock, rising edge
//   rst_in   : synchronous active-low reset
//   flush_in : synchronous FIFO clear (sticky error kept)
//   bus      : inst_encoder_if.slave (request side, result side, err_out)
// Optional feature: define ENCODER_RANGE_CHECK_EN to flag immediates that
// do not fit their format (encoded as NOP, err_out set).
module inst_encoder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           flush_in,
  inst_encoder_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R, FMT_SH
  } fmt_e;

  fmt_e        w_fmt;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_bad_type;
  logic        w_bad_imm;
  logic        w_bad;
  logic [31:0] w_word;
  logic [31:0] w_enc;

  // Type -> format, opcode, funct3, funct7
  always_comb begin
    w_fmt      = FMT_I;
    w_op       = 7'b0010011;
    w_f3       = 3'b000;
    w_f7       = 7'b0000000;
    w_bad_type = 1'b0;
    case (bus.type_in)
      `LUI:   begin w_fmt = FMT_U;  w_op = 7'b0110111; end
      `AUIPC: begin w_fmt = FMT_U;  w_op = 7'b0010111; end
      `JAL:   begin w_fmt = FMT_J;  w_op = 7'b1101111; end
      `JALR:  begin w_fmt = FMT_I;  w_op = 7'b1100111; end
      `BEQ:   begin w_fmt = FMT_B;  w_op = 7'b1100011; w_f3 = 3'b000; end
      `BNE:   begin w_fmt = FMT_B;  w_op = 7'b1100011; w_f3 = 3'b001; end
      `BLT:   begin w_fmt = FMT_B;  w_op = 7'b1100011; w_f3 = 3'b100; end
      `BGE:   begin w_fmt = FMT_B;  w_op = 7'b1100011; w_f3 = 3'b101; end
      `BLTU:  begin w_fmt = FMT_B;  w_op = 7'b1100011; w_f3 = 3'b110; end
      `BGEU:  begin w_fmt = FMT_B;  w_op = 7'b1100011; w_f3 = 3'b111; end
      `LB:    begin w_fmt = FMT_I;  w_op = 7'b0000011; w_f3 = 3'b000; end
      `LH:    begin w_fmt = FMT_I;  w_op = 7'b0000011; w_f3 = 3'b001; end
      `LW:    begin w_fmt = FMT_I;  w_op = 7'b0000011; w_f3 = 3'b010; end
      `LBU:   begin w_fmt = FMT_I;  w_op = 7'b0000011; w_f3 = 3'b100; end
      `LHU:   begin w_fmt = FMT_I;  w_op = 7'b0000011; w_f3 = 3'b101; end
      `SB:    begin w_fmt = FMT_S;  w_op = 7'b0100011; w_f3 = 3'b000; end
      `SH:    begin w_fmt = FMT_S;  w_op = 7'b0100011; w_f3 = 3'b001; end
      `SW:    begin w_fmt = FMT_S;  w_op = 7'b0100011; w_f3 = 3'b010; end
      `ADDI:  begin w_fmt = FMT_I;  w_f3 = 3'b000; end
      `SLTI:  begin w_fmt = FMT_I;  w_f3 = 3'b010; end
      `SLTIU: begin w_fmt = FMT_I;  w_f3 = 3'b011; end
      `XORI:  begin w_fmt = FMT_I;  w_f3 = 3'b100; end
      `ORI:   begin w_fmt = FMT_I;  w_f3 = 3'b110; end
      `ANDI:  begin w_fmt = FMT_I;  w_f3 = 3'b111; end
      `SLLI:  begin w_fmt = FMT_SH; w_f3 = 3'b001; end
      `SRLI:  begin w_fmt = FMT_SH; w_f3 = 3'b101; end
      `SRAI:  begin w_fmt = FMT_SH; w_f3 = 3'b101; w_f7 = 7'b0100000; end
      `ADD:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b000; end
      `SUB:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b000; w_f7 = 7'b0100000; end
      `SLL:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b001; end
      `SLT:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b010; end
      `SLTU:  begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b011; end
      `XOR:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b100; end
      `SRL:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b101; end
      `SRA:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b101; w_f7 = 7'b0100000; end
      `OR:    begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b110; end
      `AND:   begin w_fmt = FMT_R;  w_op = 7'b0110011; w_f3 = 3'b111; end
      default: w_bad_type = 1'b1;
    endcase
  end

  // Field packing; unused fields of a format are simply not referenced
  always_comb begin
    case (w_fmt)
      FMT_U:   w_word = {bus.imm_in[31:12], bus.rd_in, w_op};
      FMT_J:   w_word = {bus.imm_in[20], bus.imm_in[10:1], bus.imm_in[11],
                         bus.imm_in[19:12], bus.rd_in, w_op};
      FMT_S:   w_word = {bus.imm_in[11:5], bus.rs2_in, bus.rs1_in, w_f3,
                         bus.imm_in[4:0], w_op};
      FMT_B:   w_word = {bus.imm_in[12], bus.imm_in[10:5], bus.rs2_in, bus.rs1_in,
                         w_f3, bus.imm_in[4:1], bus.imm_in[11], w_op};
      FMT_R:   w_word = {w_f7, bus.rs2_in, bus.rs1_in, w_f3, bus.rd_in, w_op};
      FMT_SH:  w_word = {w_f7, bus.imm_in[4:0], bus.rs1_in, w_f3, bus.rd_in, w_op};
      default: w_word = {bus.imm_in[11:0], bus.rs1_in, w_f3, bus.rd_in, w_op};
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] w_simm;
  assign w_simm = $signed(bus.imm_in);

  // Immediate must be representable in its format
  always_comb begin
    w_bad_imm = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: w_bad_imm = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
      FMT_B:        w_bad_imm = (w_simm < -32'sd4096) || (w_simm > 32'sd4094) ||
                                bus.imm_in[0];
      FMT_J:        w_bad_imm = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574) ||
                                bus.imm_in[0];
      FMT_U:        w_bad_imm = |bus.imm_in[11:0];
      FMT_SH:       w_bad_imm = |bus.imm_in[31:5];
      default:      w_bad_imm = 1'b0;
    endcase
  end
`else
  assign w_bad_imm = 1'b0;
`endif

  assign w_bad = w_bad_type | w_bad_imm;
  assign w_enc = w_bad ? NOP : w_word;

  // FIFO state
  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_inst_out;
  logic             r_inst_valid;
  logic             r_req_ready;
  logic             r_err;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_head_nxt;

  assign bus.req_ready  = r_req_ready;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_out   = r_inst_out;
  assign bus.err_out    = r_err;

  // Next occupancy and next head word (head kept in a register so inst_out is registered)
  always_comb begin
    w_push       = bus.req_valid && r_req_ready && !flush_in;
    w_pop        = r_inst_valid && bus.inst_ready && !flush_in;
    w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
    w_count_nxt  = r_count;
    if (flush_in) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    w_head_nxt = r_inst_out;
    if (w_count_nxt == '0) begin
      w_head_nxt = NOP;
    end else if (r_count == '0) begin
      w_head_nxt = w_enc;
    end else if (w_pop) begin
      // With one entry left the new head is the word being pushed this cycle
      w_head_nxt = (r_count == CNT_W'(1)) ? w_enc : r_mem[w_rd_ptr_inc];
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk_in) begin
    if (rst_in && w_push) begin
      r_mem[r_wr_ptr] <= w_enc;
    end
  end

  // Pointers, count, flags and sticky error
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_inst_out   <= NOP;
      r_inst_valid <= 1'b0;
      r_req_ready  <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      if (flush_in) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count      <= w_count_nxt;
      r_inst_out   <= w_head_nxt;
      r_inst_valid <= (w_count_nxt != '0);
      r_req_ready  <= (w_count_nxt != CNT_W'(DEPTH));
      if (w_push && w_bad) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors plus randomized
// traffic against a queue-based reference model.
`ifndef INST_TYPE_CODES_DEFINED
`define INST_TYPE_CODES_DEFINED
`define TYPE_BIT 6
`define LUI   6'd0
`define JAL   6'd2
`define BEQ   6'd4
`define SW    6'd17
`define ADDI  6'd18
`define XORI  6'd21
`define SRAI  6'd26
`define SUB   6'd28
`endif

module tb_inst_encoder;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_in;
  logic flush_in;

  inst_encoder_if bus();

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_q[$];
  logic        m_err;

  // Reference encoder: instruction type numbering LUI=0 .. AND=36
  function automatic logic [31:0] ref_encode(input int t, input logic [4:0] a,
      input logic [4:0] b, input logic [4:0] d, input logic [31:0] imm, output bit bad);
    logic [31:0] bf3 [6]  = '{32'd0, 32'd1, 32'd4, 32'd5, 32'd6, 32'd7};
    logic [31:0] lf3 [5]  = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5};
    logic [31:0] af3 [6]  = '{32'd0, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7};
    logic [31:0] rf3 [10] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5, 32'd6, 32'd7};
    logic [31:0] op, f3, f7, r1, r2, rd, w;
    int fmt, sv;
    r1 = 32'(a); r2 = 32'(b); rd = 32'(d);
    op = 32'h13; f3 = 0; f7 = 0; fmt = 2;
    sv = $signed(imm);
    bad = 1'b0;
    if (t < 0 || t > 36) begin
      bad = 1'b1;
      return NOP;
    end
    if (t <= 1)       begin fmt = 0; op = (t == 0) ? 32'h37 : 32'h17; end
    else if (t == 2)  begin fmt = 1; op = 32'h6F; end
    else if (t == 3)  begin fmt = 2; op = 32'h67; end
    else if (t <= 9)  begin fmt = 4; op = 32'h63; f3 = bf3[t-4]; end
    else if (t <= 14) begin fmt = 2; op = 32'h03; f3 = lf3[t-10]; end
    else if (t <= 17) begin fmt = 3; op = 32'h23; f3 = 32'(t - 15); end
    else if (t <= 23) begin fmt = 2; op = 32'h13; f3 = af3[t-18]; end
    else if (t <= 26) begin fmt = 6; op = 32'h13; f3 = (t == 24) ? 32'd1 : 32'd5;
                            f7 = (t == 26) ? 32'h20 : 32'h0; end
    else              begin fmt = 5; op = 32'h33; f3 = rf3[t-27];
                            f7 = (t == 28 || t == 34) ? 32'h20 : 32'h0; end
`ifdef ENCODER_RANGE_CHECK_EN
    case (fmt)
      0: bad = (imm[11:0] != 12'h0);
      1: bad = (sv < -1048576) || (sv > 1048574) || (sv % 2 != 0);
      2, 3: bad = (sv < -2048) || (sv > 2047);
      4: bad = (sv < -4096) || (sv > 4094) || (sv % 2 != 0);
      default: bad = (fmt == 6) && (imm > 32'd31);
    endcase
    if (bad) return NOP;
`else
    if (sv == 0) bad = 1'b0;
`endif
    case (fmt)
      0: w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
      1: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      2: w = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
      3: w = (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
             ((imm & 32'h1F) << 7) | op;
      4: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r2 << 20) |
             (r1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | op;
      5: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
      default: w = (f7 << 25) | ((imm & 32'h1F) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
    endcase
    return w;
  endfunction

  // One clock edge; the model follows the queue rules on the same edge
  task automatic step();
    bit do_pop, do_push, bad;
    logic [31:0] w;
    @(posedge clk);
    if (!rst_in) begin
      m_q.delete();
      m_err = 1'b0;
    end else if (flush_in) begin
      m_q.delete();
    end else begin
      do_pop  = (m_q.size() > 0) && bus.inst_ready;
      do_push = bus.req_valid && (m_q.size() < int'(DEPTH));
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        w = ref_encode(int'(bus.type_in), bus.rs1_in, bus.rs2_in, bus.rd_in, bus.imm_in, bad);
        m_q.push_back(w);
        if (bad) m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_req(input logic v, input logic [`TYPE_BIT-1:0] t, input logic [4:0] a,
      input logic [4:0] b, input logic [4:0] d, input logic [31:0] imm);
    bus.req_valid = v; bus.type_in = t; bus.rs1_in = a; bus.rs2_in = b;
    bus.rd_in = d; bus.imm_in = imm;
  endtask

  task automatic rand_req(input logic v, input int max_t);
    logic [31:0] imm;
    case ($urandom_range(0, 2))
      0:       imm = $urandom();
      1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      default: imm = 32'($urandom_range(0, 31));
    endcase
    set_req(v, `TYPE_BIT'($urandom_range(0, max_t)), 5'($urandom()), 5'($urandom()),
            5'($urandom()), imm);
  endtask

  task automatic do_reset();
    rst_in = 1'b0; flush_in = 1'b0; bus.inst_ready = 1'b0;
    set_req(1'b0, `ADDI, 0, 0, 0, 0);
    step(); step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    n_checks++; if (bus.inst_out !== NOP) begin n_fail++; $display("FAIL reset_out got=%h exp=%h", bus.inst_out, NOP); end
    n_checks++; if (bus.err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.err_out); end
  endtask

  task automatic test_encode_vectors();
    logic [`TYPE_BIT-1:0] vt [6] = '{`ADDI, `LUI, `SUB, `BEQ, `JAL, `SW};
    logic [4:0]  va [6] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd1};
    logic [4:0]  vb [6] = '{5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd2};
    logic [4:0]  vd [6] = '{5'd1, 5'd5, 5'd3, 5'd0, 5'd1, 5'd0};
    logic [31:0] vi [6] = '{32'd5, 32'h1234_5000, 32'd0, 32'hFFFF_FFFC, 32'd8, 32'd8};
    logic [31:0] ve [6] = '{32'h0050_0093, 32'h1234_52B7, 32'h4020_81B3,
                            32'hFE20_8EE3, 32'h0080_00EF, 32'h0020_A423};
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, vt[i], va[i], vb[i], vd[i], vi[i]);
      step();
      bus.req_valid = 1'b0;
      n_checks++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid got=%b exp=1", i, bus.inst_valid); end
      n_checks++; if (bus.inst_out !== ve[i]) begin n_fail++; $display("FAIL vec%0d_word got=%h exp=%h", i, bus.inst_out, ve[i]); end
      step();
    end
    n_checks++; if (bus.err_out !== 1'b0) begin n_fail++; $display("FAIL vec_err got=%b exp=0", bus.err_out); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e [3];
    bit bad;
    do_reset();
    for (int i = 0; i < 3; i++)
      e[i] = ref_encode(int'(`XORI), 5'(i + 1), 5'd0, 5'(i + 4), 32'(100 + i), bad);
    set_req(1'b1, `XORI, 5'd1, 5'd0, 5'd4, 32'd100); step();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got=%b exp=1", bus.req_ready); end
    set_req(1'b1, `XORI, 5'd2, 5'd0, 5'd5, 32'd101); step();
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got=%b exp=0", bus.req_ready); end
    set_req(1'b1, `XORI, 5'd3, 5'd0, 5'd6, 32'd102); step();
    n_checks++; if (bus.inst_out !== e[0]) begin n_fail++; $display("FAIL bp_hold got=%h exp=%h", bus.inst_out, e[0]); end
    bus.inst_ready = 1'b1; step();
    n_checks++; if (bus.inst_out !== e[1]) begin n_fail++; $display("FAIL bp_second got=%h exp=%h", bus.inst_out, e[1]); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_freed got=%b exp=1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (bus.inst_out !== e[2]) begin n_fail++; $display("FAIL bp_third got=%h exp=%h", bus.inst_out, e[2]); end
    step();
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", bus.inst_valid); end
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_head;
    do_reset();
    rand_req(1'b1, 36); step();
    rand_req(1'b1, 36); step();
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", bus.req_ready); end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_req(1'b1, 36);
      step();
      exp_head = (m_q.size() > 0) ? m_q[0] : NOP;
      n_checks++; if (bus.inst_out !== exp_head) begin n_fail++; $display("FAIL wrap%0d_word got=%h exp=%h", i, bus.inst_out, exp_head); end
      n_checks++; if (bus.req_ready !== (m_q.size() != int'(DEPTH))) begin n_fail++; $display("FAIL wrap%0d_ready got=%b exp=%b", i, bus.req_ready, m_q.size() != int'(DEPTH)); end
    end
    bus.req_valid = 1'b0; bus.inst_ready = 1'b0;
  endtask

  task automatic test_range_and_illegal();
    do_reset();
    bus.inst_ready = 1'b1;
    set_req(1'b1, `ADDI, 5'd0, 5'd0, 5'd1, 32'd2048); step();
    bus.req_valid = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
    n_checks++; if (bus.inst_out !== NOP) begin n_fail++; $display("FAIL range_word got=%h exp=%h", bus.inst_out, NOP); end
    n_checks++; if (bus.err_out !== 1'b1) begin n_fail++; $display("FAIL range_err got=%b exp=1", bus.err_out); end
`else
    n_checks++; if (bus.inst_out !== 32'h8000_0093) begin n_fail++; $display("FAIL range_word got=%h exp=80000093", bus.inst_out); end
    n_checks++; if (bus.err_out !== 1'b0) begin n_fail++; $display("FAIL range_err got=%b exp=0", bus.err_out); end
`endif
    step();
    set_req(1'b1, `TYPE_BIT'(45), 5'd3, 5'd4, 5'd5, 32'd7); step();
    bus.req_valid = 1'b0;
    n_checks++; if (bus.inst_out !== NOP) begin n_fail++; $display("FAIL illegal_word got=%h exp=%h", bus.inst_out, NOP); end
    n_checks++; if (bus.err_out !== 1'b1) begin n_fail++; $display("FAIL illegal_err got=%b exp=1", bus.err_out); end
    step();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_flush();
    // err_out is already set from the illegal-type request
    set_req(1'b1, `SRAI, 5'd1, 5'd0, 5'd2, 32'd3); step();
    set_req(1'b1, `ADDI, 5'd1, 5'd0, 5'd2, 32'd3); step();
    flush_in = 1'b1; step();
    flush_in = 1'b0; bus.req_valid = 1'b0;
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", bus.inst_valid); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", bus.req_ready); end
    n_checks++; if (bus.err_out !== 1'b1) begin n_fail++; $display("FAIL flush_err got=%b exp=1", bus.err_out); end
  endtask

  task automatic test_reset_mid();
    set_req(1'b1, `SUB, 5'd1, 5'd2, 5'd3, 32'd0); step();
    set_req(1'b1, `TYPE_BIT'(60), 5'd1, 5'd2, 5'd3, 32'd0); step();
    rst_in = 1'b0; step();
    rst_in = 1'b1; bus.req_valid = 1'b0;
    n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", bus.inst_valid); end
    n_checks++; if (bus.inst_out !== NOP) begin n_fail++; $display("FAIL rstmid_out got=%h exp=%h", bus.inst_out, NOP); end
    n_checks++; if (bus.err_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got=%b exp=0", bus.err_out); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_random();
    logic [31:0] exp_head;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_req(1'($urandom_range(0, 9) < 7), 38);
      bus.inst_ready = 1'($urandom_range(0, 9) < 6);
      flush_in = 1'($urandom_range(0, 99) < 3);
      step();
      flush_in = 1'b0;
      exp_head = (m_q.size() > 0) ? m_q[0] : NOP;
      n_checks++; if (bus.inst_out !== exp_head) begin n_fail++; $display("FAIL rnd%0d_word got=%h exp=%h", i, bus.inst_out, exp_head); end
      n_checks++; if (bus.inst_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd%0d_valid got=%b exp=%b", i, bus.inst_valid, m_q.size() != 0); end
      n_checks++; if (bus.req_ready !== (m_q.size() != int'(DEPTH))) begin n_fail++; $display("FAIL rnd%0d_ready got=%b exp=%b", i, bus.req_ready, m_q.size() != int'(DEPTH)); end
      n_checks++; if (bus.err_out !== m_err) begin n_fail++; $display("FAIL rnd%0d_err got=%b exp=%b", i, bus.err_out, m_err); end
    end
  endtask

  initial begin
    m_err = 1'b0;
    test_reset();
    test_encode_vectors();
    test_backpressure();
    test_full_wrap();
    test_range_and_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
